// File: rtl/accum_seq_if.sv
// accum_seq_if: job request and issue/framing bus of the accumulator sequencer
interface accum_seq_if #(
  parameter int VEC_ADDRW = 9,
  parameter int MAT_ADDRW = 9
);
  logic                 start;
  logic [VEC_ADDRW-1:0] vec_base;
  logic [MAT_ADDRW-1:0] mat_base;
  logic [VEC_ADDRW-1:0] num_cols;
  logic [MAT_ADDRW-1:0] num_rows;
  logic [VEC_ADDRW-1:0] vec_raddr;
  logic [MAT_ADDRW-1:0] mat_raddr;
  logic                 ovalid;
  logic                 first;
  logic                 last;
  logic                 busy;
  logic                 done;
  logic                 err;
  modport master (
    output start, vec_base, mat_base, num_cols, num_rows,
    input  vec_raddr, mat_raddr, ovalid, first, last, busy, done, err
  );
  modport slave (
    input  start, vec_base, mat_base, num_cols, num_rows,
    output vec_raddr, mat_raddr, ovalid, first, last, busy, done, err
  );
endinterface

// File: rtl/accum_seq.sv
// accum_seq: issues vector/matrix read addresses and latency-aligned dot-product framing.
// Optional ACCUM_SEQ_ZERO_CHK_EN rejects jobs with a zero row or column count.
module accum_seq #(
  parameter int VEC_ADDRW = 9,
  parameter int MAT_ADDRW = 9,
  parameter int MEM_LAT   = 2
) (
  input logic        clk,
  input logic        rst,
  accum_seq_if.slave s
);
  localparam int DW = $clog2(MEM_LAT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t st;
  logic [VEC_ADDRW-1:0] vb, ncm1, c, c_nx, vaddr;
  logic [MAT_ADDRW-1:0] nrm1, r, maddr;
  logic [DW-1:0] dcnt;
  logic iv, ifst, ilst, busy, done, err;
  logic col_end, job_end, zero;
  logic [2:0] dl [MEM_LAT];
`ifdef ACCUM_SEQ_ZERO_CHK_EN
  assign zero = s.num_cols == '0 || s.num_rows == '0;
`else
  assign zero = 1'b0;
`endif
  assign col_end = c == ncm1;
  assign job_end = col_end && r == nrm1;
  assign c_nx = col_end ? '0 : c + VEC_ADDRW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      vb <= '0;
      ncm1 <= '0;
      nrm1 <= '0;
      c <= '0;
      r <= '0;
      vaddr <= '0;
      maddr <= '0;
      dcnt <= '0;
      iv <= 1'b0;
      ifst <= 1'b0;
      ilst <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) dl[i] <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      dl[0] <= {iv, ifst, ilst};
      for (int i = 1; i < MEM_LAT; i++) dl[i] <= dl[i-1];
      case (st)
        IDLE: if (s.start) begin
          if (zero) err <= 1'b1;
          else begin
            st <= ISSUE;
            busy <= 1'b1;
            vb <= s.vec_base;
            ncm1 <= s.num_cols - VEC_ADDRW'(1);
            nrm1 <= s.num_rows - MAT_ADDRW'(1);
            c <= '0;
            r <= '0;
            vaddr <= s.vec_base;
            maddr <= s.mat_base;
            iv <= 1'b1;
            ifst <= 1'b1;
            ilst <= s.num_cols == VEC_ADDRW'(1);
          end
        end
        ISSUE: if (job_end) begin
          st <= DRAIN;
          iv <= 1'b0;
          ifst <= 1'b0;
          ilst <= 1'b0;
          dcnt <= '0;
        end else begin
          c <= c_nx;
          if (col_end) r <= r + MAT_ADDRW'(1);
          vaddr <= vb + c_nx;
          maddr <= maddr + MAT_ADDRW'(1);
          ifst <= c_nx == '0;
          ilst <= c_nx == ncm1;
        end
        // Hold until the last issued word has left the delay line.
        DRAIN: if (dcnt == DW'(MEM_LAT - 1)) begin
          st <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else dcnt <= dcnt + DW'(1);
        default: st <= IDLE;
      endcase
    end
  end
  assign s.vec_raddr = vaddr;
  assign s.mat_raddr = maddr;
  assign s.ovalid = dl[MEM_LAT-1][2];
  assign s.first = dl[MEM_LAT-1][2] & dl[MEM_LAT-1][1];
  assign s.last = dl[MEM_LAT-1][2] & dl[MEM_LAT-1][0];
  assign s.busy = busy;
  assign s.done = done;
  assign s.err = err;
endmodule
